// File: rtl/sisc_loader_pkg.sv
// Shared encodings and widths for the SISC instruction-memory boot loader.
package sisc_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RECV  = 2'b01,
        ST_WRITE = 2'b10,
        ST_FIN   = 2'b11
    } state_e;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; the register self-clears
// when a word completes so the next word starts from zero.
module word_packer
    import sisc_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_f,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word_next_c,
    output logic              o_word_full_c
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [WORD_W-1:0]     r_word;
    logic [4:0]            w_lsb;

    // First byte lands in the top lane: lane offset is (3 - count) * 8.
    assign w_lsb         = {~r_cnt, 3'b000};
    assign o_word_next_c = r_word | WORD_W'(i_byte);
    assign o_word_full_c = i_load && (r_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_cnt <= r_cnt + BYTE_CNT_W'(1);
            if (o_word_full_c) begin
                r_word <= '0;
            end else begin
                r_word[w_lsb +: 8] <= i_byte;
            end
        end
    end

endmodule

// File: rtl/im_boot_loader.sv
// Boot-time writer for the SISC instruction memory: packs a byte stream into
// words, writes them to consecutive addresses and then releases the core.
module im_boot_loader
    import sisc_loader_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst_f,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned          CHK_W    = ADDR_W + 1;
    localparam logic [CHK_W-1:0]     LOAD_MAX = CHK_W'(MEM_DEPTH - BASE_ADDR);
    localparam logic [ADDR_W-1:0]    BASE     = ADDR_W'(BASE_ADDR);

    state_e              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_count, w_count_nxt;
    logic [ADDR_W-1:0]   r_word_idx, w_word_idx_nxt;
    logic                r_byte_ready, w_byte_ready_nxt;
    logic                r_im_we, w_im_we_nxt;
    logic [ADDR_W-1:0]   r_im_addr, w_im_addr_nxt;
    logic [WORD_W-1:0]   r_im_wdata, w_im_wdata_nxt;
    logic                r_cpu_rst_f, w_cpu_rst_f_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;

    logic                w_start_ok;
    logic [ADDR_W-1:0]   w_idx_inc;
    logic                w_pack_clear;
    logic                w_accept;
    logic [WORD_W-1:0]   w_word_next;
    logic                w_word_full;

    word_packer u_packer (
        .clk           (clk),
        .rst_f         (rst_f),
        .i_clear       (w_pack_clear),
        .i_load        (w_accept),
        .i_byte        (byte_in),
        .o_word_next_c (w_word_next),
        .o_word_full_c (w_word_full)
    );

    assign w_start_ok = (word_count != '0) && ({1'b0, word_count} <= LOAD_MAX);
    assign w_idx_inc  = r_word_idx + ADDR_W'(1);

    // Next state plus next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_word_idx_nxt  = r_word_idx;
        w_im_addr_nxt   = r_im_addr;
        w_im_wdata_nxt  = r_im_wdata;
        w_cpu_rst_f_nxt = r_cpu_rst_f;
        w_err_nxt       = r_err;
        w_pack_clear    = 1'b0;
        w_accept        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_start_ok) begin
                        w_count_nxt     = word_count;
                        w_word_idx_nxt  = '0;
                        w_err_nxt       = 1'b0;
                        w_cpu_rst_f_nxt = 1'b0;
                        w_pack_clear    = 1'b1;
                        w_state_nxt     = ST_RECV;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                w_accept = byte_valid && r_byte_ready;
                if (w_word_full) begin
                    w_im_addr_nxt  = BASE + r_word_idx;
                    w_im_wdata_nxt = w_word_next;
                    w_state_nxt    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_word_idx_nxt = w_idx_inc;
                w_state_nxt    = (w_idx_inc == r_count) ? ST_FIN : ST_RECV;
            end
            ST_FIN: begin
                w_cpu_rst_f_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_byte_ready_nxt = (w_state_nxt == ST_RECV);
        w_im_we_nxt      = (w_state_nxt == ST_WRITE);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_done_nxt       = (w_state_nxt == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_ready <= 1'b0;
            r_im_we      <= 1'b0;
            r_im_addr    <= BASE;
            r_im_wdata   <= '0;
            r_cpu_rst_f  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_byte_ready <= w_byte_ready_nxt;
            r_im_we      <= w_im_we_nxt;
            r_im_addr    <= w_im_addr_nxt;
            r_im_wdata   <= w_im_wdata_nxt;
            r_cpu_rst_f  <= w_cpu_rst_f_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign byte_ready = r_byte_ready;
    assign im_we      = r_im_we;
    assign im_addr    = r_im_addr;
    assign im_wdata   = r_im_wdata;
    assign cpu_rst_f  = r_cpu_rst_f;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader: byte-stream loads checked against a
// word-level scoreboard and an instruction-memory model.
module tb_im_boot_loader;

    localparam int unsigned BASE  = 0;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, im_we, cpu_rst_f, busy, done, err;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;

    im_boot_loader #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_rst_f  (cpu_rst_f),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [47:0] exp_q[$];
    logic [31:0] mem[DEPTH];
    logic        memv[DEPTH];
    int          n_we = 0;
    int          n_done = 0;
    int          cyc = 0;
    int          last_hs = -10;
    logic        prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory-side monitor: scoreboard of writes, done pulses and core release.
    always @(negedge clk) begin
        if (!rst_f) begin
            prev_done = 1'b0;
        end else begin
            cyc++;
            if (prev_done) check("cpu_release_after_fin", 32'(cpu_rst_f), 32'd1);
            if (busy) check("cpu_held_while_busy", 32'(cpu_rst_f), 32'd0);
            if (im_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    logic [47:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(im_addr), 32'(e[47:32]));
                    check("write_data", im_wdata, e[31:0]);
                end
                check("write_latency", 32'(cyc - last_hs), 32'd1);
                mem[im_addr[9:0]]  = im_wdata;
                memv[im_addr[9:0]] = 1'b1;
                n_we++;
            end
            if (done) n_done++;
            prev_done = done;
            if (byte_valid && byte_ready) last_hs = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] cnt);
        tick();
        start      = 1'b1;
        word_count = cnt;
        tick();
        start = 1'b0;
    endtask

    // Feed bytes; gap_idx >= 0 forces one idle gap, otherwise gaps are random.
    task automatic send_bytes(input logic [7:0] bq[$], input int gap_idx, input int gap_len,
                              input int busy_idx);
        for (int k = 0; k < bq.size(); k++) begin
            int   gaps;
            int   guard;
            logic hs;
            if (gap_idx >= 0) gaps = (k == gap_idx) ? gap_len : 0;
            else gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            byte_valid = 1'b0;
            repeat (gaps) tick();
            byte_valid = 1'b1;
            byte_in    = bq[k];
            if (k == busy_idx) begin
                start      = 1'b1;
                word_count = 16'd5;
            end
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                @(negedge clk);
                hs = byte_ready;
                tick();
                start = 1'b0;
                guard++;
            end
            if (!hs) check("byte_accept_timeout", 32'd0, 32'd1);
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input int cnt, input logic [7:0] bq[$], input int gap_idx,
                            input int gap_len, input int busy_idx);
        int we0, d0, g;
        for (int i = 0; i < cnt; i++)
            exp_q.push_back({16'(BASE + i), bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]});
        we0 = n_we;
        d0  = n_done;
        pulse_start(16'(cnt));
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_clear_on_start", 32'(err), 32'd0);
        send_bytes(bq, gap_idx, gap_len, busy_idx);
        g = 0;
        while (n_done == d0 && g < 30) begin
            tick();
            g++;
        end
        if (n_done == d0) check("done_timeout", 32'd0, 32'd1);
        tick();
        tick();
        check("write_count", 32'(n_we - we0), 32'(cnt));
        check("done_once", 32'(n_done - d0), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("err_after_load", 32'(err), 32'd0);
        check("busy_after_load", 32'(busy), 32'd0);
        check("cpu_running", 32'(cpu_rst_f), 32'd1);
    endtask

    function automatic void rand_bytes(input int nb, output logic [7:0] bq[$]);
        bq = {};
        for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] bq[$];
        int         we0;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = '0;
            memv[i] = 1'b0;
        end

        // Reset then idle
        repeat (3) tick();
        rst_f = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_cpu_rst_f", 32'(cpu_rst_f), 32'd0);
            check("idle_byte_ready", 32'(byte_ready), 32'd0);
            check("idle_im_we", 32'(im_we), 32'd0);
            check("idle_im_addr", 32'(im_addr), 32'(BASE));
        end
        check("idle_err", 32'(err), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_wdata", im_wdata, 32'd0);

        // Two-word load with continuous bytes
        bq = '{8'h88, 8'h00, 8'h00, 8'h01, 8'h20, 8'h10, 8'h00, 8'h00};
        run_load(2, bq, 0, 0, -1);
        check("mem0_two_word", mem[0], 32'h8800_0001);
        check("mem1_two_word", mem[1], 32'h2010_0000);

        // Stalled stream: valid drops for 3 cycles before the third byte
        bq = '{8'hde, 8'had, 8'hbe, 8'hef};
        run_load(1, bq, 2, 3, -1);
        check("mem0_stalled", mem[0], 32'hdead_beef);

        // Rejected starts, then a valid start clears err
        pulse_start(16'd0);
        check("err_count_zero", 32'(err), 32'd1);
        check("ready_count_zero", 32'(byte_ready), 32'd0);
        repeat (3) tick();
        check("ready_still_idle", 32'(byte_ready), 32'd0);
        check("busy_still_idle", 32'(busy), 32'd0);
        check("err_sticky", 32'(err), 32'd1);
        pulse_start(16'(DEPTH - BASE + 1));
        check("err_count_too_big", 32'(err), 32'd1);
        check("busy_count_too_big", 32'(busy), 32'd0);
        check("cpu_kept_on_reject", 32'(cpu_rst_f), 32'd1);
        rand_bytes(4, bq);
        run_load(1, bq, -1, 0, -1);

        // Start while busy is ignored
        rand_bytes(12, bq);
        run_load(3, bq, -1, 0, 5);

        // Random loads
        for (int r = 0; r < 6; r++) begin
            int cnt;
            cnt = int'($urandom_range(1, 8));
            rand_bytes(4 * cnt, bq);
            run_load(cnt, bq, -1, 0, -1);
        end

        // Largest legal load fills the whole region
        rand_bytes(4 * (DEPTH - BASE), bq);
        run_load(DEPTH - BASE, bq, -1, 0, -1);
        check("mem_last_word", mem[DEPTH-1], {bq[bq.size()-4], bq[bq.size()-3],
                                              bq[bq.size()-2], bq[bq.size()-1]});

        // Reset mid-load after word 0 and two bytes of word 1
        for (int i = 0; i < DEPTH; i++) memv[i] = 1'b0;
        rand_bytes(8, bq);
        for (int i = 0; i < 2; i++)
            exp_q.push_back({16'(BASE + i), bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]});
        we0 = n_we;
        pulse_start(16'd2);
        begin
            logic [7:0] part[$];
            part = bq[0:5];
            send_bytes(part, -1, 0, -1);
        end
        rst_f = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        check("midrst_cpu_held", 32'(cpu_rst_f), 32'd0);
        check("midrst_we", 32'(im_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_f = 1'b1;
        byte_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            byte_in = 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
        tick();
        check("midrst_writes", 32'(n_we - we0), 32'd1);
        check("midrst_word0_valid", 32'(memv[BASE]), 32'd1);
        check("midrst_word0_data", mem[BASE], {bq[0], bq[1], bq[2], bq[3]});
        check("midrst_word1_absent", 32'(memv[BASE+1]), 32'd0);
        check("midrst_cpu_still_held", 32'(cpu_rst_f), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
